// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN calculator front end: debounce FSM states
// and the default qualification time.
package rpn_pkg;

    // 10 ms at 100 MHz
    localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_PRESS   = 2'd1,
        PRESSED      = 2'd2,
        WAIT_RELEASE = 2'd3
    } deb_state_t;

endpackage

// File: rtl/rpn_button_conditioner_if.sv
// Button-side bundle of the conditioner: raw levels in, pulses and debounced
// levels out. The master drives the buttons, the slave is the conditioner.
interface rpn_button_conditioner_if;

    logic btn_enter;
    logic btn_undo;
    logic Enter_pulse;
    logic deb_undo;
    logic enter_level;
    logic undo_level;

    modport master (
        output btn_enter,
        output btn_undo,
        input  Enter_pulse,
        input  deb_undo,
        input  enter_level,
        input  undo_level
    );

    modport slave (
        input  btn_enter,
        input  btn_undo,
        output Enter_pulse,
        output deb_undo,
        output enter_level,
        output undo_level
    );

endinterface

// File: rtl/button_debouncer.sv
// One button: 2-flop synchronizer, 4-state debounce FSM with a saturating
// qualification counter, registered one-shot press pulse and debounced level.
module button_debouncer
    import rpn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic Reset,
    input  logic btn,
    output logic pulse,
    output logic level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_SAT  = CW'(DEBOUNCE_CYCLES);

    logic [1:0]    sync_reg;
    deb_state_t    state_reg;
    logic [CW-1:0] cnt_reg;
    logic          pulse_reg;
    logic          level_reg;
    logic          sync;

    // sync_reg[0] may go metastable; only sync_reg[1] is used by the FSM
    assign sync = sync_reg[1];

    always_ff @(posedge clk) begin
        if (Reset) begin
            sync_reg  <= 2'b00;
            state_reg <= IDLE;
            cnt_reg   <= '0;
            pulse_reg <= 1'b0;
            level_reg <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[0], btn};
            pulse_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    level_reg <= 1'b0;
                    if (sync) begin
                        state_reg <= WAIT_PRESS;
                        cnt_reg   <= '0;
                    end
                end
                WAIT_PRESS: begin
                    if (!sync) begin
                        state_reg <= IDLE;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg <= PRESSED;
                        pulse_reg <= 1'b1;
                        level_reg <= 1'b1;
                    end else begin
                        cnt_reg <= (cnt_reg == CNT_SAT) ? cnt_reg : cnt_reg + 1'b1;
                    end
                end
                PRESSED: begin
                    level_reg <= 1'b1;
                    if (!sync) begin
                        state_reg <= WAIT_RELEASE;
                        cnt_reg   <= '0;
                    end
                end
                WAIT_RELEASE: begin
                    // a bounce back high resumes the press without a new pulse
                    if (sync) begin
                        state_reg <= PRESSED;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg <= IDLE;
                        level_reg <= 1'b0;
                    end else begin
                        cnt_reg <= (cnt_reg == CNT_SAT) ? cnt_reg : cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    level_reg <= 1'b0;
                end
            endcase
        end
    end

    assign pulse = pulse_reg;
    assign level = level_reg;

endmodule

// File: rtl/rpn_button_conditioner.sv
// Conditions the Enter and Undo push-buttons for the RPN control FSM; two
// independent debouncers, no arbitration between them.
module rpn_button_conditioner
    import rpn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic Reset,
    input  logic btn_enter,
    input  logic btn_undo,
    output logic Enter_pulse,
    output logic deb_undo,
    output logic enter_level,
    output logic undo_level
);

    // bit 0 = Enter, bit 1 = Undo
    logic [1:0] btn_vec;
    logic [1:0] pulse_vec;
    logic [1:0] level_vec;

    assign btn_vec = {btn_undo, btn_enter};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            button_debouncer #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_deb (
                .clk   (clk),
                .Reset (Reset),
                .btn   (btn_vec[gi]),
                .pulse (pulse_vec[gi]),
                .level (level_vec[gi])
            );
        end
    endgenerate

    assign Enter_pulse = pulse_vec[0];
    assign deb_undo    = pulse_vec[1];
    assign enter_level = level_vec[0];
    assign undo_level  = level_vec[1];

endmodule

// File: tb/tb_rpn_button_conditioner.sv
// Bench for rpn_button_conditioner with DEBOUNCE_CYCLES=4: a table of input
// segments with expected pulse edges (scoreboarded) and levels, plus a
// cycle-exact latency sequence.
module tb_rpn_button_conditioner;

    localparam int N = 4;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    typedef struct {
        logic rst;
        logic en;
        logic un;
        int   len;   // edges the inputs are held
        int   ep;    // segment edge after which Enter_pulse is high, 0 = none
        int   up;    // same for deb_undo
        logic el;    // enter_level after the last edge
        logic ul;    // undo_level after the last edge
    } seg_t;

    logic clk = 1'b0;
    logic Reset;
    always #5 clk = ~clk;

    rpn_button_conditioner_if bif();

    rpn_button_conditioner #(
        .DEBOUNCE_CYCLES(N)
    ) dut (
        .clk         (clk),
        .Reset       (Reset),
        .btn_enter   (bif.btn_enter),
        .btn_undo    (bif.btn_undo),
        .Enter_pulse (bif.Enter_pulse),
        .deb_undo    (bif.deb_undo),
        .enter_level (bif.enter_level),
        .undo_level  (bif.undo_level)
    );

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   q_enter[$];
    int   q_undo[$];
    logic prev_e = 1'b0;
    logic prev_u = 1'b0;
    seg_t segs[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: every observed pulse must match the oldest expectation.
    always @(negedge clk) begin
        int ex;
        if (bif.Enter_pulse === 1'b1) begin
            checks++;
            if (prev_e) begin
                failures++;
                $display("FAIL enter_pulse_width edge=%0d got high two cycles, required one", cyc);
            end else if (q_enter.size() == 0) begin
                failures++;
                $display("FAIL enter_pulse_unexpected edge=%0d got pulse, required none", cyc);
            end else begin
                ex = q_enter.pop_front();
                if (ex != cyc) begin
                    failures++;
                    $display("FAIL enter_pulse_time got edge %0d, required edge %0d", cyc, ex);
                end
            end
        end
        if (bif.deb_undo === 1'b1) begin
            checks++;
            if (prev_u) begin
                failures++;
                $display("FAIL undo_pulse_width edge=%0d got high two cycles, required one", cyc);
            end else if (q_undo.size() == 0) begin
                failures++;
                $display("FAIL undo_pulse_unexpected edge=%0d got pulse, required none", cyc);
            end else begin
                ex = q_undo.pop_front();
                if (ex != cyc) begin
                    failures++;
                    $display("FAIL undo_pulse_time got edge %0d, required edge %0d", cyc, ex);
                end
            end
        end
        prev_e = (bif.Enter_pulse === 1'b1);
        prev_u = (bif.deb_undo === 1'b1);
    end

    function automatic void add(input logic r, input logic e, input logic u, input int len,
                                input int ep, input int up, input logic el, input logic ul);
        seg_t s;
        s.rst = r; s.en = e; s.un = u; s.len = len;
        s.ep = ep; s.up = up; s.el = el; s.ul = ul;
        segs.push_back(s);
    endfunction

    task automatic drive_seg(input int idx, input seg_t sg);
        int s;
        Reset         = sg.rst;
        bif.btn_enter = sg.en;
        bif.btn_undo  = sg.un;
        s = cyc + 1;
        if (sg.ep > 0) q_enter.push_back(s + sg.ep - 1);
        if (sg.up > 0) q_undo.push_back(s + sg.up - 1);
        repeat (sg.len) @(negedge clk);
        checks += 2;
        if (bif.enter_level !== sg.el) begin
            failures++;
            $display("FAIL seg%0d_enter_level got %b, required %b", idx, bif.enter_level, sg.el);
        end
        if (bif.undo_level !== sg.ul) begin
            failures++;
            $display("FAIL seg%0d_undo_level got %b, required %b", idx, bif.undo_level, sg.ul);
        end
        if (sg.rst) begin
            checks++;
            if (bif.Enter_pulse !== 1'b0 || bif.deb_undo !== 1'b0) begin
                failures++;
                $display("FAIL seg%0d_reset_pulses got %b%b, required 00", idx,
                         bif.Enter_pulse, bif.deb_undo);
            end
        end
        $display("seg %0d rst=%b en=%b un=%b len=%0d -> enter_level=%b undo_level=%b",
                 idx, sg.rst, sg.en, sg.un, sg.len, bif.enter_level, bif.undo_level);
    endtask

    initial begin
        Reset         = 1'b1;
        bif.btn_enter = 1'b0;
        bif.btn_undo  = 1'b0;

        add(H, L, L, 3,  0, 0, L, L);   // reset
        add(L, H, L, 6,  7, 0, L, L);   // clean press, still qualifying
        add(L, H, L, 4,  0, 0, H, L);   // pulse lands on first edge here
        add(L, L, L, 6,  0, 0, H, L);   // release, level still high
        add(L, L, L, 4,  0, 0, L, L);   // level dropped at release edge 7
        add(L, H, L, 4,  0, 0, L, L);   // bounce just before completion
        add(L, L, L, 1,  0, 0, L, L);
        add(L, H, L, 10, 7, 0, H, L);   // requalifies from zero
        add(L, L, L, 10, 0, 0, L, L);
        add(L, L, H, 2,  0, 0, L, L);   // undo toggles every 2 cycles
        add(L, L, L, 2,  0, 0, L, L);
        add(L, L, H, 2,  0, 0, L, L);
        add(L, L, L, 2,  0, 0, L, L);
        add(L, L, H, 10, 0, 7, L, H);   // final rise
        add(L, L, L, 10, 0, 0, L, L);
        add(L, H, L, 50, 7, 0, H, L);   // long hold: one pulse
        add(L, L, L, 6,  0, 0, H, L);
        add(L, L, L, 14, 0, 0, L, L);
        add(L, H, L, 12, 7, 0, H, L);   // second press
        add(L, L, L, 10, 0, 0, L, L);
        add(L, H, H, 10, 7, 7, H, H);   // simultaneous
        add(L, L, L, 10, 0, 0, L, L);
        add(L, H, L, 3,  0, 0, L, L);   // reset at press edge 4
        add(H, H, L, 3,  0, 0, L, L);
        add(L, H, L, 10, 7, 0, H, L);
        add(L, L, L, 10, 0, 0, L, L);
        add(L, L, H, 10, 0, 7, L, H);   // reset while pressed
        add(H, L, H, 1,  0, 0, L, L);
        add(L, L, H, 10, 0, 7, L, H);
        add(L, L, L, 10, 0, 0, L, L);

        @(negedge clk);
        for (int i = 0; i < segs.size(); i++) drive_seg(i, segs[i]);

        // Cycle-exact latency: pulse only after edge 7, level from then on.
        bif.btn_enter = 1'b1;
        q_enter.push_back(cyc + 7);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            checks += 3;
            if (bif.Enter_pulse !== (k == 7)) begin
                failures++;
                $display("FAIL latency_pulse edge%0d got %b, required %b", k, bif.Enter_pulse, (k == 7));
            end
            if (bif.enter_level !== (k >= 7)) begin
                failures++;
                $display("FAIL latency_level edge%0d got %b, required %b", k, bif.enter_level, (k >= 7));
            end
            if (bif.deb_undo !== 1'b0) begin
                failures++;
                $display("FAIL latency_undo edge%0d got %b, required 0", k, bif.deb_undo);
            end
            $display("latency edge %0d pulse=%b level=%b", k, bif.Enter_pulse, bif.enter_level);
        end
        bif.btn_enter = 1'b0;
        repeat (12) @(negedge clk);

        checks++;
        if (q_enter.size() != 0 || q_undo.size() != 0) begin
            failures++;
            $display("FAIL missing_pulses got %0d enter and %0d undo outstanding, required 0",
                     q_enter.size(), q_undo.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
